// File: rtl/lstm_fx_pkg.sv
// Fixed-point helpers shared by the LSTM cell: gate indices, FSM states and
// clamping/activation functions evaluated on a 64-bit signed carrier.
package lstm_fx_pkg;

    localparam int unsigned FX_W      = 64;
    localparam int unsigned NUM_GATES = 4;
    localparam int unsigned GATE_A    = 0;
    localparam int unsigned GATE_I    = 1;
    localparam int unsigned GATE_F    = 2;
    localparam int unsigned GATE_O    = 3;

    typedef logic signed [FX_W-1:0] fx_t;

    typedef enum logic [2:0] {StIdle, StAcc, StAct, StCst, StHout} state_e;

    function automatic fx_t fx_one(input int unsigned frac);
        return fx_t'(1) <<< frac;
    endfunction

    function automatic fx_t fx_max(input int unsigned w);
        return (fx_t'(1) <<< (w - 1)) - fx_t'(1);
    endfunction

    function automatic fx_t fx_min(input int unsigned w);
        return -(fx_t'(1) <<< (w - 1));
    endfunction

    // Clamp v into the signed range of a w-bit word (w < FX_W).
    function automatic fx_t sat(input fx_t v, input int unsigned w);
        if (v > fx_max(w)) return fx_max(w);
        if (v < fx_min(w)) return fx_min(w);
        return v;
    endfunction

    function automatic fx_t htanh(input fx_t v, input int unsigned frac);
        if (v > fx_one(frac)) return fx_one(frac);
        if (v < -fx_one(frac)) return -fx_one(frac);
        return v;
    endfunction

    function automatic fx_t hsig(input fx_t v, input int unsigned frac);
        fx_t t;
        t = (v >>> 2) + (fx_one(frac) >>> 1);
        if (t > fx_one(frac)) return fx_one(frac);
        if (t < fx_t'(0)) return fx_t'(0);
        return t;
    endfunction

endpackage

// File: rtl/lstm_mac_sat.sv
// Fixed-point product: full-width signed multiply, floor shift by FRAC,
// clamped to ACC_W bits. Needs 2*WIDTH <= 64 and ACC_W < 64.
module lstm_mac_sat
    import lstm_fx_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 24,
    parameter int unsigned ACC_W = 40
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [ACC_W-1:0] p_o
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;

    assign prod    = PROD_W'(a_i) * PROD_W'(b_i);
    assign shifted = prod >>> FRAC;
    assign p_o     = ACC_W'(sat(fx_t'(shifted), ACC_W));

endmodule

// File: rtl/lstm_cell_seq.sv
// Streaming single-unit LSTM cell: accumulates x*W and h*U per gate, then
// activates, updates the cell state and emits h with a one-cycle o_valid.
module lstm_cell_seq
    import lstm_fx_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 24,
    parameter int unsigned X_LEN = 2,
    parameter int unsigned H_LEN = 1,
    parameter int unsigned GUARD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_b_a,
    input  logic [WIDTH-1:0] i_b_i,
    input  logic [WIDTH-1:0] i_b_f,
    input  logic [WIDTH-1:0] i_b_o,
    input  logic [WIDTH-1:0] i_prev_state,
    input  logic             i_x_valid,
    output logic             o_x_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_w_a,
    input  logic [WIDTH-1:0] i_w_i,
    input  logic [WIDTH-1:0] i_w_f,
    input  logic [WIDTH-1:0] i_w_o,
    input  logic             i_h_valid,
    output logic             o_h_ready,
    input  logic [WIDTH-1:0] i_h,
    input  logic [WIDTH-1:0] i_u_a,
    input  logic [WIDTH-1:0] i_u_i,
    input  logic [WIDTH-1:0] i_u_f,
    input  logic [WIDTH-1:0] i_u_o,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_i,
    output logic [WIDTH-1:0] o_f,
    output logic [WIDTH-1:0] o_o,
    output logic [WIDTH-1:0] o_c,
    output logic [WIDTH-1:0] o_h
);

    localparam int unsigned ACC_W = WIDTH + GUARD;
    localparam int unsigned XC_W  = $clog2(X_LEN + 1);
    localparam int unsigned HC_W  = $clog2(H_LEN + 1);

    typedef logic signed [WIDTH-1:0] word_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    state_e          state_q;
    acc_t            acc_q [NUM_GATES];
    acc_t            acc_d [NUM_GATES];
    word_t           c_prev_q;
    logic [XC_W-1:0] x_cnt_q, x_cnt_d;
    logic [HC_W-1:0] h_cnt_q, h_cnt_d;

    word_t bias  [NUM_GATES];
    word_t w     [NUM_GATES];
    word_t u     [NUM_GATES];
    word_t mac_a [NUM_GATES];
    word_t mac_b [NUM_GATES];
    word_t act   [NUM_GATES];
    acc_t  px    [NUM_GATES];
    acc_t  ph    [NUM_GATES];
    word_t c_new, h_new;
    logic  x_fire, h_fire, acc_done;

    assign bias[GATE_A] = i_b_a;
    assign bias[GATE_I] = i_b_i;
    assign bias[GATE_F] = i_b_f;
    assign bias[GATE_O] = i_b_o;
    assign w[GATE_A]    = i_w_a;
    assign w[GATE_I]    = i_w_i;
    assign w[GATE_F]    = i_w_f;
    assign w[GATE_O]    = i_w_o;
    assign u[GATE_A]    = i_u_a;
    assign u[GATE_I]    = i_u_i;
    assign u[GATE_F]    = i_u_f;
    assign u[GATE_O]    = i_u_o;

    assign o_busy    = (state_q != StIdle);
    assign o_x_ready = (state_q == StAcc) && (x_cnt_q < XC_W'(X_LEN));
    assign o_h_ready = (state_q == StAcc) && (h_cnt_q < HC_W'(H_LEN));
    assign x_fire    = i_x_valid && o_x_ready;
    assign h_fire    = i_h_valid && o_h_ready;
    assign x_cnt_d   = x_cnt_q + XC_W'(x_fire);
    assign h_cnt_d   = h_cnt_q + HC_W'(h_fire);
    assign acc_done  = (x_cnt_d == XC_W'(X_LEN)) && (h_cnt_d == HC_W'(H_LEN));

    // Outside ACC the x-path multipliers are idle, so they compute the
    // cell-state and hidden-output products instead.
    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            mac_a[g] = i_x;
            mac_b[g] = w[g];
        end
        if (state_q != StAcc) begin
            mac_a[GATE_A] = '0;
            mac_b[GATE_A] = '0;
            mac_a[GATE_I] = o_i;
            mac_b[GATE_I] = o_a;
            mac_a[GATE_F] = o_f;
            mac_b[GATE_F] = c_prev_q;
            mac_a[GATE_O] = o_o;
            mac_b[GATE_O] = word_t'(htanh(fx_t'($signed(o_c)), FRAC));
        end
    end

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        lstm_mac_sat #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_mac_x (
            .a_i (mac_a[g]),
            .b_i (mac_b[g]),
            .p_o (px[g])
        );
        lstm_mac_sat #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_mac_h (
            .a_i (i_h),
            .b_i (u[g]),
            .p_o (ph[g])
        );
    end

    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            acc_d[g] = acc_t'(sat(fx_t'(acc_q[g])
                                  + (x_fire ? fx_t'(px[g]) : fx_t'(0))
                                  + (h_fire ? fx_t'(ph[g]) : fx_t'(0)), ACC_W));
            if (g == GATE_A) act[g] = word_t'(htanh(sat(fx_t'(acc_q[g]), WIDTH), FRAC));
            else             act[g] = word_t'(hsig(sat(fx_t'(acc_q[g]), WIDTH), FRAC));
        end
        c_new = word_t'(sat(fx_t'(px[GATE_F]) + fx_t'(px[GATE_I]), WIDTH));
        h_new = word_t'(sat(fx_t'(px[GATE_O]), WIDTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            for (int g = 0; g < NUM_GATES; g++) acc_q[g] <= '0;
            c_prev_q <= '0;
            x_cnt_q  <= '0;
            h_cnt_q  <= '0;
            o_valid  <= 1'b0;
            o_a      <= '0;
            o_i      <= '0;
            o_f      <= '0;
            o_o      <= '0;
            o_c      <= '0;
            o_h      <= '0;
        end else begin
            o_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        for (int g = 0; g < NUM_GATES; g++) acc_q[g] <= acc_t'(bias[g]);
                        c_prev_q <= i_prev_state;
                        x_cnt_q  <= '0;
                        h_cnt_q  <= '0;
                        state_q  <= StAcc;
                    end
                end
                StAcc: begin
                    for (int g = 0; g < NUM_GATES; g++) acc_q[g] <= acc_d[g];
                    x_cnt_q <= x_cnt_d;
                    h_cnt_q <= h_cnt_d;
                    if (acc_done) state_q <= StAct;
                end
                StAct: begin
                    o_a     <= act[GATE_A];
                    o_i     <= act[GATE_I];
                    o_f     <= act[GATE_F];
                    o_o     <= act[GATE_O];
                    state_q <= StCst;
                end
                StCst: begin
                    o_c     <= c_new;
                    state_q <= StHout;
                end
                StHout: begin
                    o_h     <= h_new;
                    o_valid <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_cell_seq.sv
// Directed bench for lstm_cell_seq: one single-beat instance and one X_LEN=2
// instance sharing the data inputs, each started by its own i_start.
module tb_lstm_cell_seq;

    localparam logic [31:0] E_A = 32'h00A66666;
    localparam logic [31:0] E_I = 32'h00E66666;
    localparam logic [31:0] E_F = 32'h00B66666;
    localparam logic [31:0] E_O = 32'h00ACCCCC;
    localparam logic [31:0] E_C = 32'h0095C28E;
    localparam logic [31:0] E_H = 32'h00651685;
    localparam logic [31:0] ONE = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [31:0] b_a = '0, b_i = '0, b_f = '0, b_o = '0, prev = '0;
    logic [31:0] x = '0, w_a = '0, w_i = '0, w_f = '0, w_o = '0;
    logic [31:0] h = '0, u_a = '0, u_i = '0, u_f = '0, u_o = '0;
    logic        x_valid = 1'b0, h_valid = 1'b0;

    logic        x_ready1, h_ready1, busy1, valid1;
    logic [31:0] a1, i1, f1, o1, c1, h1;
    logic        x_ready2, h_ready2, busy2, valid2;
    logic [31:0] a2, i2, f2, o2, c2, h2;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    lstm_cell_seq #(.WIDTH(32), .FRAC(24), .X_LEN(1), .H_LEN(1), .GUARD(8)) u_dut1 (
        .clk (clk), .rst (rst), .i_start (start1),
        .i_b_a (b_a), .i_b_i (b_i), .i_b_f (b_f), .i_b_o (b_o), .i_prev_state (prev),
        .i_x_valid (x_valid), .o_x_ready (x_ready1), .i_x (x),
        .i_w_a (w_a), .i_w_i (w_i), .i_w_f (w_f), .i_w_o (w_o),
        .i_h_valid (h_valid), .o_h_ready (h_ready1), .i_h (h),
        .i_u_a (u_a), .i_u_i (u_i), .i_u_f (u_f), .i_u_o (u_o),
        .o_busy (busy1), .o_valid (valid1),
        .o_a (a1), .o_i (i1), .o_f (f1), .o_o (o1), .o_c (c1), .o_h (h1)
    );

    lstm_cell_seq #(.WIDTH(32), .FRAC(24), .X_LEN(2), .H_LEN(1), .GUARD(8)) u_dut2 (
        .clk (clk), .rst (rst), .i_start (start2),
        .i_b_a (b_a), .i_b_i (b_i), .i_b_f (b_f), .i_b_o (b_o), .i_prev_state (prev),
        .i_x_valid (x_valid), .o_x_ready (x_ready2), .i_x (x),
        .i_w_a (w_a), .i_w_i (w_i), .i_w_f (w_f), .i_w_o (w_o),
        .i_h_valid (h_valid), .o_h_ready (h_ready2), .i_h (h),
        .i_u_a (u_a), .i_u_i (u_i), .i_u_f (u_f), .i_u_o (u_o),
        .o_busy (busy2), .o_valid (valid2),
        .o_a (a2), .o_i (i2), .o_f (f2), .o_o (o2), .o_c (c2), .o_h (h2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic;
        b_a = 32'h00333333; b_i = 32'h00A66666; b_f = 32'h00266666; b_o = 32'h00199999;
        w_a = 32'h00733333; w_i = 32'h00F33333; w_f = 32'h00B33333; w_o = 32'h00999999;
        u_a = 32'h00400000; u_i = 32'h00400000; u_f = 32'h00400000; u_o = 32'h00400000;
        prev = '0; x = ONE; h = '0;
    endtask

    task automatic set_all(input logic [31:0] bias, input logic [31:0] wt, input logic [31:0] d);
        b_a = bias; b_i = bias; b_f = bias; b_o = bias;
        w_a = wt; w_i = wt; w_f = wt; w_o = wt;
        u_a = wt; u_i = wt; u_f = wt; u_o = wt;
        x = d; h = d; prev = '0;
    endtask

    task automatic start_one;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    task automatic both_beats;
        x_valid = 1'b1;
        h_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        h_valid = 1'b0;
    endtask

    task automatic wait_valid1(input string tag);
        int n = 0;
        while (!valid1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(valid1), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_x_ready", 32'(x_ready1), 32'd0);
        check("rst_h_ready", 32'(h_ready1), 32'd0);
        check("rst_o_a", a1, 32'd0);
        check("rst_o_c", c1, 32'd0);
        check("rst_o_h", h1, 32'd0);
        rst = 1'b1;
        tick();

        // Basic single-beat run
        set_basic();
        start_one();
        check("basic_busy", 32'(busy1), 32'd1);
        check("basic_x_ready", 32'(x_ready1), 32'd1);
        check("basic_h_ready", 32'(h_ready1), 32'd1);
        both_beats();
        check("basic_x_ready_done", 32'(x_ready1), 32'd0);
        wait_valid1("basic_valid");
        check("basic_o_a", a1, E_A);
        check("basic_o_i", i1, E_I);
        check("basic_o_f", f1, E_F);
        check("basic_o_o", o1, E_O);
        check("basic_o_c", c1, E_C);
        check("basic_o_h", h1, E_H);
        tick();
        check("basic_pulse_end", 32'(valid1), 32'd0);
        check("basic_hold_h", h1, E_H);
        check("basic_idle", 32'(busy1), 32'd0);

        // Back-pressure: x held valid for three cycles, h arrives later
        start_one();
        x_valid = 1'b1;
        tick();
        check("bp_x_ready_drop", 32'(x_ready1), 32'd0);
        check("bp_h_ready", 32'(h_ready1), 32'd1);
        x = 32'h7FFFFFFF;
        h_valid = 1'b1;
        tick();
        h_valid = 1'b0;
        tick();
        x_valid = 1'b0;
        wait_valid1("bp_valid");
        check("bp_o_a", a1, E_A);
        check("bp_o_c", c1, E_C);
        check("bp_o_h", h1, E_H);

        // Positive saturation
        set_all(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        start_one();
        both_beats();
        wait_valid1("satp_valid");
        check("satp_o_a", a1, ONE);
        check("satp_o_i", i1, ONE);
        check("satp_o_f", f1, ONE);
        check("satp_o_o", o1, ONE);
        check("satp_o_c", c1, ONE);
        check("satp_o_h", h1, ONE);

        // Negative saturation
        set_all(32'h80000000, 32'h80000000, 32'h7FFFFFFF);
        start_one();
        both_beats();
        wait_valid1("satn_valid");
        check("satn_o_a", a1, 32'hFF000000);
        check("satn_o_i", i1, 32'd0);
        check("satn_o_f", f1, 32'd0);
        check("satn_o_o", o1, 32'd0);
        check("satn_o_c", c1, 32'd0);

        // Reset in the middle of accumulation
        set_basic();
        start_one();
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_o_a", a1, 32'd0);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_x_ready", 32'(x_ready1), 32'd0);
        tick();
        check("abort_valid", 32'(valid1), 32'd0);
        rst = 1'b1;
        tick();
        start_one();
        both_beats();
        wait_valid1("abort_rerun_valid");
        check("abort_rerun_o_c", c1, E_C);
        check("abort_rerun_o_h", h1, E_H);

        // i_start while busy is ignored
        set_basic();
        start_one();
        both_beats();
        set_all(32'h7FFFFFFF, 32'h00733333, ONE);
        start1 = 1'b1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (n == 1) start1 = 1'b0;
            if (valid1) pulses++;
        end
        check("busy_start_pulses", 32'(pulses), 32'd1);
        check("busy_start_o_h", h1, E_H);
        check("busy_start_idle", 32'(busy1), 32'd0);

        // X_LEN=2: x and h together, then a second x that cancels the h term
        set_basic();
        h = ONE;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        both_beats();
        check("dual_x_ready", 32'(x_ready2), 32'd1);
        check("dual_h_ready", 32'(h_ready2), 32'd0);
        x = 32'hFF000000;
        w_a = 32'h00400000; w_i = 32'h00400000; w_f = 32'h00400000; w_o = 32'h00400000;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        check("dual_lat_e0", 32'(valid2), 32'd0);
        tick();
        check("dual_lat_e1", 32'(valid2), 32'd0);
        tick();
        check("dual_lat_e2", 32'(valid2), 32'd0);
        tick();
        check("dual_lat_e3", 32'(valid2), 32'd1);
        check("dual_o_a", a2, E_A);
        check("dual_o_i", i2, E_I);
        check("dual_o_f", f2, E_F);
        check("dual_o_o", o2, E_O);
        check("dual_o_c", c2, E_C);
        check("dual_o_h", h2, E_H);
        tick();
        check("dual_pulse_end", 32'(valid2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
